// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - two-requester round-robin 8N1 transmit scheduler
// Shares one external baud generator and the tx line; every output is registered.
module uart_tx_sched #(
  parameter int TICKS_PER_FRAME = 9,
  parameter int TIMEOUT_CYCLES  = 20000
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       req_a_valid,
  input  logic [7:0] req_a_data,
  output logic       req_a_ready,
  input  logic       req_b_valid,
  input  logic [7:0] req_b_data,
  output logic       req_b_ready,
  output logic       baud_trigger,
  output logic       baud_enable,
  input  logic       baud_status,
  input  logic       baud_tick,
  output logic       tx,
  output logic       busy,
  output logic       err_timeout
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, SHIFT, DRAIN} state_t;

  localparam logic [14:0] TIMER_LIMIT = 15'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  LAST_TICK   = 4'(TICKS_PER_FRAME - 1);

  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [14:0] timer_q, timer_d;
  logic        last_grant_q, last_grant_d;  // 1: B was served last
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        ready_a_q, ready_a_d;
  logic        ready_b_q, ready_b_d;
  logic        trigger_q, trigger_d;
  logic        enable_q, enable_d;
  logic        err_q, err_d;
  logic        grant_a;
  logic        abort;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q      <= IDLE;
      shift_q      <= 8'h00;
      bit_cnt_q    <= 4'd0;
      timer_q      <= 15'd0;
      last_grant_q <= 1'b1;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      ready_a_q    <= 1'b0;
      ready_b_q    <= 1'b0;
      trigger_q    <= 1'b0;
      enable_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      timer_q      <= timer_d;
      last_grant_q <= last_grant_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      ready_a_q    <= ready_a_d;
      ready_b_q    <= ready_b_d;
      trigger_q    <= trigger_d;
      enable_q     <= enable_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    timer_d      = timer_q;
    last_grant_d = last_grant_q;
    tx_d         = tx_q;
    busy_d       = busy_q;
    ready_a_d    = 1'b0;
    ready_b_d    = 1'b0;
    trigger_d    = 1'b0;
    enable_d     = 1'b0;
    err_d        = 1'b0;
    grant_a      = 1'b0;
    abort        = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        // The generator may still be running after a reset; wait for it to go idle.
        if ((req_a_valid || req_b_valid) && !baud_status) begin
          grant_a      = req_a_valid && (!req_b_valid || last_grant_q);
          ready_a_d    = grant_a;
          ready_b_d    = !grant_a;
          shift_d      = grant_a ? req_a_data : req_b_data;
          last_grant_d = !grant_a;
          busy_d       = 1'b1;
          state_d      = LAUNCH;
        end
      end
      LAUNCH: begin
        trigger_d = 1'b1;
        enable_d  = 1'b1;
        tx_d      = 1'b0;
        bit_cnt_d = 4'd0;
        timer_d   = 15'd0;
        state_d   = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        tx_d = 1'b0;
        if (baud_status) begin
          timer_d = 15'd0;
          state_d = SHIFT;
        end else if (timer_q == TIMER_LIMIT) begin
          abort = 1'b1;
        end else begin
          timer_d = timer_q + 15'd1;
        end
      end
      SHIFT: begin
        // A tick on the limit cycle still counts as progress.
        if (baud_tick) begin
          tx_d      = (bit_cnt_q < 4'd8) ? shift_q[bit_cnt_q[2:0]] : 1'b1;
          bit_cnt_d = bit_cnt_q + 4'd1;
          timer_d   = 15'd0;
          if (bit_cnt_q == LAST_TICK) begin
            state_d = DRAIN;
          end
        end else if (timer_q == TIMER_LIMIT) begin
          abort = 1'b1;
        end else begin
          timer_d = timer_q + 15'd1;
        end
      end
      DRAIN: begin
        tx_d = 1'b1;
        if (!baud_status) begin
          busy_d  = 1'b0;
          timer_d = 15'd0;
          state_d = IDLE;
        end else if (timer_q == TIMER_LIMIT) begin
          abort = 1'b1;
        end else begin
          timer_d = timer_q + 15'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort) begin
      tx_d    = 1'b1;
      err_d   = 1'b1;
      busy_d  = 1'b0;
      timer_d = 15'd0;
      state_d = IDLE;
    end
  end

  assign req_a_ready  = ready_a_q;
  assign req_b_ready  = ready_b_q;
  assign baud_trigger = trigger_q;
  assign baud_enable  = enable_q;
  assign tx           = tx_q;
  assign busy         = busy_q;
  assign err_timeout  = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - scoreboard bench for uart_tx_sched with a baud generator stub
// Grants and tx bits are predicted from the requested bytes and checked as they appear.
module tb_uart_tx_sched;

  localparam int TIMEOUT = 20000;

  logic       sysclk = 1'b0;
  logic       reset;
  logic       req_a_valid;
  logic [7:0] req_a_data;
  logic       req_a_ready;
  logic       req_b_valid;
  logic [7:0] req_b_data;
  logic       req_b_ready;
  logic       baud_trigger;
  logic       baud_enable;
  logic       baud_status;
  logic       baud_tick;
  logic       tx;
  logic       busy;
  logic       err_timeout;

  always #5 sysclk = ~sysclk;

  uart_tx_sched #(.TICKS_PER_FRAME(9), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .sysclk(sysclk), .reset(reset),
    .req_a_valid(req_a_valid), .req_a_data(req_a_data), .req_a_ready(req_a_ready),
    .req_b_valid(req_b_valid), .req_b_data(req_b_data), .req_b_ready(req_b_ready),
    .baud_trigger(baud_trigger), .baud_enable(baud_enable),
    .baud_status(baud_status), .baud_tick(baud_tick),
    .tx(tx), .busy(busy), .err_timeout(err_timeout)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] a_q[$];
  logic [7:0] b_q[$];
  logic [8:0] exp_grant_q[$];
  logic       exp_tx_q[$];

  int cycle = 0;
  int trig_cycle = 0;
  int err_seen = 0;
  int ph = 0;
  int cnt = 0;
  int tick_idx = 0;
  int tick_gap = 4;
  int long_idx = -1;
  int long_gap = 0;
  bit never_busy = 1'b0;
  bit stray_pending = 1'b0;
  bit tick_chk = 1'b0;
  bit trig_chk = 1'b0;
  logic busy_prev = 1'b0;
  logic ra_prev = 1'b0;
  logic rb_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  task automatic handle_grant(input logic who);
    logic [8:0] e;
    check_eq("grant_status_idle", 32'(baud_status), 0);
    check_eq("grant_busy", 32'(busy), 1);
    check_eq("grant_pending", 32'(exp_grant_q.size() > 0), 1);
    if (exp_grant_q.size() > 0) begin
      e = exp_grant_q.pop_front();
      check_eq("grant_who", 32'(who), 32'(e[8]));
      for (int i = 0; i < 8; i++) exp_tx_q.push_back(e[i]);
      exp_tx_q.push_back(1'b1);
    end
    if (who && b_q.size() > 0) void'(b_q.pop_front());
    if (!who && a_q.size() > 0) void'(a_q.pop_front());
    trig_chk = 1'b1;
  endtask

  // One clock: observe DUT outputs at the falling edge, then drive requesters and the stub.
  task automatic step();
    logic exp_bit;
    @(negedge sysclk);
    cycle++;
    if (tick_chk) begin
      tick_chk = 1'b0;
      exp_bit = (exp_tx_q.size() > 0) ? exp_tx_q.pop_front() : 1'b1;
      check_eq("tx_bit", 32'(tx), 32'(exp_bit));
    end
    if (trig_chk) begin
      trig_chk = 1'b0;
      check_eq("launch_trigger", 32'(baud_trigger), 1);
      check_eq("launch_enable", 32'(baud_enable), 1);
      check_eq("launch_tx", 32'(tx), 0);
    end
    if (baud_trigger) trig_cycle = cycle;
    if (req_a_ready) begin
      check_eq("ready_a_single", 32'(ra_prev), 0);
      check_eq("ready_exclusive", 32'(req_b_ready), 0);
      handle_grant(1'b0);
    end
    if (req_b_ready) begin
      check_eq("ready_b_single", 32'(rb_prev), 0);
      handle_grant(1'b1);
    end
    if (err_timeout) begin
      err_seen++;
      check_eq("timeout_latency", 32'(cycle - trig_cycle), TIMEOUT);
      check_eq("timeout_tx", 32'(tx), 1);
      check_eq("timeout_busy", 32'(busy), 0);
      exp_tx_q.delete();
    end
    if (busy_prev && !busy && !err_timeout && !reset) begin
      check_eq("busy_fall_status", 32'(baud_status), 0);
      check_eq("frame_bits_left", 32'(exp_tx_q.size()), 0);
    end
    busy_prev = busy;
    ra_prev = req_a_ready;
    rb_prev = req_b_ready;

    req_a_valid = (a_q.size() > 0);
    req_a_data  = (a_q.size() > 0) ? a_q[0] : 8'h00;
    req_b_valid = (b_q.size() > 0);
    req_b_data  = (b_q.size() > 0) ? b_q[0] : 8'h00;

    baud_tick = 1'b0;
    case (ph)
      0: begin
        if (stray_pending) begin
          stray_pending = 1'b0;
          baud_tick = 1'b1;
          tick_chk = 1'b1;
        end else if (baud_trigger && !never_busy) begin
          ph = 1;
          cnt = 2;
        end
      end
      1: begin
        cnt--;
        if (cnt == 0) begin
          baud_status = 1'b1;
          ph = 2;
          tick_idx = 0;
          cnt = tick_gap;
        end
      end
      2: begin
        cnt--;
        if (cnt == 0) begin
          baud_tick = 1'b1;
          tick_chk = 1'b1;
          tick_idx++;
          if (tick_idx == 9) begin
            ph = 3;
            cnt = 3;
          end else begin
            cnt = (tick_idx == long_idx) ? long_gap : tick_gap;
          end
        end
      end
      3: begin
        cnt--;
        if (cnt == 0) begin
          baud_status = 1'b0;
          ph = 0;
        end
      end
      default: ph = 0;
    endcase
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < budget) begin
      step();
      n++;
      done = (exp_grant_q.size() == 0) && (a_q.size() == 0) && (b_q.size() == 0) && !busy && (ph == 0);
    end
    check_eq(tag, 32'(done), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    req_a_valid = 1'b0;
    req_a_data = 8'h00;
    req_b_valid = 1'b0;
    req_b_data = 8'h00;
    baud_status = 1'b0;
    baud_tick = 1'b0;
    repeat (3) step();
    check_eq("rst_tx", 32'(tx), 1);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_ready_a", 32'(req_a_ready), 0);
    check_eq("rst_ready_b", 32'(req_b_ready), 0);
    check_eq("rst_trigger", 32'(baud_trigger), 0);
    check_eq("rst_enable", 32'(baud_enable), 0);
    check_eq("rst_err", 32'(err_timeout), 0);
    reset = 1'b0;

    // Single byte from A
    a_q.push_back(8'h55);
    exp_grant_q.push_back({1'b0, 8'h55});
    wait_done("t1_done", 200);

    // Contention: strict alternation starting with A after reset
    do_reset();
    a_q.push_back(8'h0F);
    a_q.push_back(8'h3C);
    b_q.push_back(8'hF0);
    b_q.push_back(8'hC3);
    exp_grant_q.push_back({1'b0, 8'h0F});
    exp_grant_q.push_back({1'b1, 8'hF0});
    exp_grant_q.push_back({1'b0, 8'h3C});
    exp_grant_q.push_back({1'b1, 8'hC3});
    wait_done("t2_done", 800);

    // Generator never reports busy: abort after the full timeout
    never_busy = 1'b1;
    a_q.push_back(8'h81);
    exp_grant_q.push_back({1'b0, 8'h81});
    wait_done("t3_done", TIMEOUT + 200);
    never_busy = 1'b0;
    check_eq("t3_err_count", 32'(err_seen), 1);

    // Stray tick while idle
    stray_pending = 1'b1;
    repeat (4) step();
    check_eq("t5_busy", 32'(busy), 0);
    check_eq("t5_tx", 32'(tx), 1);

    // Tick lands exactly on the timeout limit cycle
    long_idx = 3;
    long_gap = TIMEOUT;
    a_q.push_back(8'hC5);
    exp_grant_q.push_back({1'b0, 8'hC5});
    wait_done("t6_done", TIMEOUT + 400);
    long_idx = -1;

    // Reset mid-frame with B pending
    a_q.push_back(8'hA3);
    exp_grant_q.push_back({1'b0, 8'hA3});
    n = 0;
    while (!(ph == 2 && tick_idx >= 2) && n < 200) begin
      step();
      n++;
    end
    b_q.push_back(8'h5A);
    while (!(ph == 2 && tick_idx >= 4 && !tick_chk) && n < 400) begin
      step();
      n++;
    end
    check_eq("t4_reached_tick4", 32'(tick_idx), 4);
    exp_tx_q.delete();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("t4_tx_after_reset", 32'(tx), 1);
    check_eq("t4_busy_after_reset", 32'(busy), 0);
    check_eq("t4_status_still_busy", 32'(baud_status), 1);
    exp_grant_q.push_back({1'b1, 8'h5A});
    wait_done("t4_done", 400);

    check_eq("final_err_count", 32'(err_seen), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Transmit-side controller that shares one baud generator and serial TX line between two byte requesters (A: CPU UART register write, B: auxiliary/debug source). It arbitrates requests round-robin and latches the winning byte. It launches the baud generator and shifts an 8N1 frame onto tx, one bit per baud tick. It sits between the peripheral bus logic and the baud generator at the top of the single-cycle CPU.

Parameters:
TICKS_PER_FRAME, 9, baud ticks per frame after launch (8 data bits + stop bit).
TIMEOUT_CYCLES, 20000, max sysclk cycles allowed between consecutive baud events before abort.

Ports:
sysclk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
req_a_valid  in  1  requester A has a byte; held until granted
req_a_data  in  8  requester A byte
req_a_ready  out  1  one-cycle grant pulse to A; the byte is taken on this cycle
req_b_valid  in  1  requester B has a byte
req_b_data  in  8  requester B byte
req_b_ready  out  1  one-cycle grant pulse to B
baud_trigger  out  1  launch pulse to the baud generator
baud_enable  out  1  enable to the baud generator, asserted with baud_trigger
baud_status  in  1  baud generator busy flag
baud_tick  in  1  one-cycle baud pulse from the baud generator
tx  out  1  serial line, idle high
busy  out  1  high from grant until return to IDLE
err_timeout  out  1  one-cycle pulse on abort

Behaviour:
- Reset (sync, dominant over all else): state=IDLE, tx=1, busy=0, ready outputs=0, baud_trigger=0, baud_enable=0, err_timeout=0, bit_cnt=0, timer=0, last_grant=B (so A wins the first tie).
- All outputs are registered.
- States: IDLE, LAUNCH, WAIT_BUSY, SHIFT, DRAIN.
- IDLE:
  - If (req_a_valid|req_b_valid) && baud_status==0, grant as follows:
    - Only one valid: that requester wins.
    - Both valid: the requester not equal to last_grant wins.
  - On grant: latch its data into shift_reg, pulse its ready for exactly one cycle, update last_grant, busy=1, go to LAUNCH.
  - If baud_status==1 in IDLE (generator still finishing after a reset), no grant is made.
- LAUNCH (1 cycle): baud_trigger=1, baud_enable=1, tx=0 (start bit), bit_cnt=0, timer=0; go to WAIT_BUSY.
- WAIT_BUSY: baud_trigger=0, baud_enable=0, tx held 0. When baud_status==1, go to SHIFT and clear timer.
- SHIFT:
  - On each baud_tick: if bit_cnt<8, tx=shift_reg[bit_cnt] (LSB first); if bit_cnt==8, tx=1 (stop bit).
  - Each tick increments bit_cnt and clears timer.
  - After tick number TICKS_PER_FRAME (bit_cnt reaches 9), go to DRAIN.
  - A baud_tick seen in any other state is ignored.
- DRAIN: tx=1. When baud_status==0, go to IDLE with busy=0.
  - A pending request is eligible no earlier than the cycle after IDLE is entered.
- Timeout:
  - In WAIT_BUSY, SHIFT and DRAIN, timer increments every cycle and clears on every state change or tick.
  - If timer==TIMEOUT_CYCLES-1: tx=1, err_timeout=1 for one cycle, busy=0, go to IDLE.
  - The aborted byte is dropped and is not re-requested.
- Arithmetic widths: bit_cnt is 4 bits; timer is 15 bits, saturating never exceeded because abort occurs at the limit.
- Requesters must hold valid and data stable until ready. A valid deasserted before grant is simply not served.
- Simultaneous events:
  - A tick coinciding with the timeout limit counts as a tick; no abort.
  - A reset coinciding with a grant: reset wins, no ready pulse.
- Reset mid-frame: tx=1 next edge. The external generator is not reset, so the IDLE baud_status==0 guard blocks a new launch until it finishes.

Test Plan:
1. Reset, then A valid, data 0x55 → req_a_ready pulses 1 cycle; next cycle baud_trigger=1 and tx=0; tx sequence on the 9 ticks is 1,0,1,0,1,0,1,0,1; busy drops after baud_status falls.
2. A and B valid in the same cycle after reset, A=0x0F, B=0xF0 → A is granted first, B after A's frame; with both still valid, the next grant goes to A again (strict alternation). Check ready pulses and last_grant.
3. Stub holds baud_status=0 forever after launch → err_timeout pulses exactly at 20000 cycles after LAUNCH; tx=1; busy=0; state returns to IDLE.
4. Reset asserted after 4 ticks of byte 0xA3 while baud_status is still 1 → tx=1 next edge; a pending B request is not granted until baud_status==0, then is granted.
5. Stray baud_tick while IDLE with no request → tx stays 1; no ready pulse; no state change.
6. baud_tick arriving on the cycle timer hits TIMEOUT_CYCLES-1 in SHIFT → no err_timeout; bit advances normally.
